// File: rtl/pulse_train_pkg.sv
// pulse_train_pkg: shared types and defaults for the pulse train generator.
package pulse_train_pkg;

  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pt_state_t;

endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered rising-edge detector. A level input becomes a
// one-cycle strobe on the cycle after the rise is sampled.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pedge
);

  logic r_prev;
  logic r_pedge;

  // Remember the previous level and flag a 0->1 transition one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev  <= 1'b0;
      r_pedge <= 1'b0;
    end else begin
      r_prev  <= in;
      r_pedge <= in & ~r_prev;
    end
  end

  assign pedge = r_pedge;

endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: turns a trigger strobe into a train of `reps` pulses,
// each high_len cycles high then low_len cycles low. Lengths and count are
// latched at the trigger. Optional macro PULSE_TRAIN_GEN_EDGE_EN makes
// `start` a level input passed through a registered rising-edge detector.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] reps,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = '0;

  pt_state_t        r_state;
  pt_state_t        w_next;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] w_phaseNext;
  logic [CNT_W-1:0] r_rep;
  logic [CNT_W-1:0] w_repNext;
  logic [CNT_W-1:0] r_hM1;
  logic [CNT_W-1:0] w_hM1Next;
  logic [CNT_W-1:0] r_lM1;
  logic [CNT_W-1:0] w_lM1Next;
  logic [CNT_W-1:0] w_hM1In;
  logic [CNT_W-1:0] w_lM1In;
  logic             w_doneNext;
  logic             w_trig;
  logic             r_out;
  logic             r_busy;
  logic             r_done;

`ifdef PULSE_TRAIN_GEN_EDGE_EN
  rise_detect u_rise_detect (
    .clk   (clk),
    .rst   (rst),
    .in    (start),
    .pedge (w_trig)
  );
`else
  assign w_trig = start;
`endif

  // A zero length behaves like one, so the stored reload value is max(len,1)-1
  assign w_hM1In = (high_len == ZERO) ? ZERO : (high_len - ONE);
  assign w_lM1In = (low_len  == ZERO) ? ZERO : (low_len  - ONE);

  // Next-state, counter and done-strobe logic; abort overrides everything
  always_comb begin
    w_next      = r_state;
    w_phaseNext = r_phase;
    w_repNext   = r_rep;
    w_hM1Next   = r_hM1;
    w_lM1Next   = r_lM1;
    w_doneNext  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trig && !abort && (reps != ZERO)) begin
          w_next      = HIGH;
          w_hM1Next   = w_hM1In;
          w_lM1Next   = w_lM1In;
          w_phaseNext = w_hM1In;
          w_repNext   = reps - ONE;
        end
      end
      HIGH: begin
        if (abort) begin
          w_next = IDLE;
        end else if (r_phase == ZERO) begin
          w_next      = LOW;
          w_phaseNext = r_lM1;
        end else begin
          w_phaseNext = r_phase - ONE;
        end
      end
      LOW: begin
        if (abort) begin
          w_next = IDLE;
        end else if (r_phase == ZERO) begin
          if (r_rep == ZERO) begin
            w_next     = IDLE;
            w_doneNext = 1'b1;
          end else begin
            w_next      = HIGH;
            w_repNext   = r_rep - ONE;
            w_phaseNext = r_hM1;
          end
        end else begin
          w_phaseNext = r_phase - ONE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State, counters and outputs registered together so outputs track the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_rep   <= '0;
      r_hM1   <= '0;
      r_lM1   <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_phase <= w_phaseNext;
      r_rep   <= w_repNext;
      r_hM1   <= w_hM1Next;
      r_lM1   <= w_lM1Next;
      r_out   <= (w_next == HIGH);
      r_busy  <= (w_next != IDLE);
      r_done  <= w_doneNext;
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed stimulus with a timing-arithmetic model of the
// pulse train checked every cycle, plus hand-computed literal expectations.
module tb_pulse_train_gen;

`ifdef PULSE_TRAIN_GEN_EDGE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] highLen = 8'd0;
  logic [7:0] lowLen = 8'd0;
  logic [7:0] reps = 8'd0;
  logic       out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  int doneSeen = 0;

  // Model state: when the current train was accepted and its parameters
  int  edgeCnt = 0;
  bit  mActive = 1'b0;
  int  mK = 0;
  int  mH = 0;
  int  mL = 0;
  int  mR = 0;
  bit  mPedge = 1'b0;
  bit  mPrev = 1'b0;
  bit  expOut;
  bit  expBusy;
  bit  expDone;

  always #5 clk = ~clk;

  pulse_train_gen #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .high_len (highLen),
    .low_len  (lowLen),
    .reps     (reps),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] l, input logic [7:0] r);
    highLen = h;
    lowLen  = l;
    reps    = r;
  endtask

  task automatic advance(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Called 1ns after an edge; returns 1ns after the edge at which the FSM accepts
  task automatic strobeStart();
    start = 1'b1;
    advance(1);
    start = 1'b0;
    advance(LAT);
  endtask

  // Model: outputs after edge n follow from elapsed edges since acceptance
  initial begin
    int e;
    int per;
    int tot;
    bit preBusy;
    bit trig;
    forever begin
      @(posedge clk);
      edgeCnt++;
      if (!rst) begin
        mActive = 1'b0;
        mPedge  = 1'b0;
        mPrev   = 1'b0;
      end else begin
        preBusy = mActive && ((edgeCnt - 1 - mK) < mR * (mH + mL));
`ifdef PULSE_TRAIN_GEN_EDGE_EN
        trig   = mPedge;
        mPedge = start && !mPrev;
        mPrev  = start;
`else
        trig = start;
`endif
        if (abort && preBusy) begin
          mActive = 1'b0;
        end else if (!preBusy && trig && !abort && reps != 0) begin
          mActive = 1'b1;
          mK = edgeCnt;
          mH = (highLen == 0) ? 1 : int'(highLen);
          mL = (lowLen == 0) ? 1 : int'(lowLen);
          mR = int'(reps);
        end
      end
      expOut = 1'b0;
      expBusy = 1'b0;
      expDone = 1'b0;
      if (mActive) begin
        e = edgeCnt - mK;
        per = mH + mL;
        tot = mR * per;
        expBusy = (e < tot);
        expOut = (e < tot) && ((e % per) < mH);
        expDone = (e == tot);
      end
      #1;
      checkOutput("model out", {31'd0, out}, {31'd0, expOut});
      checkOutput("model busy", {31'd0, busy}, {31'd0, expBusy});
      checkOutput("model done", {31'd0, done}, {31'd0, expDone});
      if (done === 1'b1) doneSeen++;
    end
  end

  initial begin
    int riseCount;
    logic prevOut;

    #1;
    checkOutput("reset out", {31'd0, out}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    advance(2);

    $display("[TB] basic train");
    applyStimulus(8'd3, 8'd2, 8'd2);
    strobeStart();
    checkOutput("basic e0 out", {31'd0, out}, 32'd1);
    checkOutput("basic e0 busy", {31'd0, busy}, 32'd1);
    advance(3);
    checkOutput("basic e3 out", {31'd0, out}, 32'd0);
    advance(2);
    checkOutput("basic e5 out", {31'd0, out}, 32'd1);
    advance(4);
    checkOutput("basic e9 busy", {31'd0, busy}, 32'd1);
    advance(1);
    checkOutput("basic e10 done", {31'd0, done}, 32'd1);
    checkOutput("basic e10 busy", {31'd0, busy}, 32'd0);
    advance(1);
    checkOutput("basic e11 done", {31'd0, done}, 32'd0);
    advance(2);

    $display("[TB] zero lengths");
    applyStimulus(8'd0, 8'd0, 8'd1);
    strobeStart();
    checkOutput("zero e0 out", {31'd0, out}, 32'd1);
    advance(1);
    checkOutput("zero e1 out", {31'd0, out}, 32'd0);
    checkOutput("zero e1 busy", {31'd0, busy}, 32'd1);
    advance(1);
    checkOutput("zero e2 done", {31'd0, done}, 32'd1);
    advance(2);

    $display("[TB] zero reps");
    applyStimulus(8'd4, 8'd4, 8'd0);
    strobeStart();
    checkOutput("reps0 busy", {31'd0, busy}, 32'd0);
    advance(3);
    checkOutput("reps0 busy later", {31'd0, busy}, 32'd0);

    $display("[TB] start while busy");
    applyStimulus(8'd5, 8'd5, 8'd1);
    doneSeen = 0;
    strobeStart();
    advance(3);
    applyStimulus(8'd1, 8'd1, 8'd3);
    strobeStart();
    advance(6 - LAT);
    checkOutput("retrig e10 done", {31'd0, done}, 32'd1);
    advance(4);
    checkOutput("retrig done count", doneSeen, 32'd1);

    $display("[TB] abort mid high");
    applyStimulus(8'd4, 8'd2, 8'd2);
    doneSeen = 0;
    strobeStart();
    advance(1);
    abort = 1'b1;
    advance(1);
    checkOutput("abort out", {31'd0, out}, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    abort = 1'b0;
    advance(8);
    checkOutput("abort done count", doneSeen, 32'd0);

    $display("[TB] abort with start in idle");
    start = 1'b1;
    abort = 1'b1;
    advance(1 + LAT);
    start = 1'b0;
    abort = 1'b0;
    advance(1);
    checkOutput("abort+start busy", {31'd0, busy}, 32'd0);
    advance(2);
    checkOutput("abort+start out", {31'd0, out}, 32'd0);

    $display("[TB] async reset mid low");
    applyStimulus(8'd3, 8'd3, 8'd1);
    strobeStart();
    advance(4);
    checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async out", {31'd0, out}, 32'd0);
    checkOutput("async busy", {31'd0, busy}, 32'd0);
    checkOutput("async done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    advance(1);
    doneSeen = 0;
    strobeStart();
    advance(5);
    checkOutput("post-reset e5 busy", {31'd0, busy}, 32'd1);
    advance(1);
    checkOutput("post-reset e6 done", {31'd0, done}, 32'd1);
    advance(1);
    checkOutput("post-reset done count", doneSeen, 32'd1);
    advance(2);

    $display("[TB] start held high");
    applyStimulus(8'd1, 8'd1, 8'd1);
    riseCount = 0;
    prevOut = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      advance(1);
`ifdef PULSE_TRAIN_GEN_EDGE_EN
      if (i == 0) checkOutput("edge rise+1 out", {31'd0, out}, 32'd0);
      if (i == 1) checkOutput("edge rise+2 out", {31'd0, out}, 32'd1);
`else
      if (i == 0) checkOutput("held first out", {31'd0, out}, 32'd1);
`endif
      if (out === 1'b1 && prevOut === 1'b0) riseCount++;
      prevOut = out;
    end
    start = 1'b0;
    advance(4);
`ifdef PULSE_TRAIN_GEN_EDGE_EN
    checkOutput("held pulse count", riseCount, 32'd1);
`else
    checkOutput("held pulse count", riseCount, 32'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
